// File: rtl/issue_reorder_window.sv
// ----------------------------------------------------------------------------
// issue_reorder_window
//
// Small reorder buffer between decode and issue. It holds up to DEPTH decoded
// instructions in program order (slot 0 is the oldest). When empty, it passes
// the decode entry straight through to issue with zero latency. When the head
// is a LOAD/STORE stalled on a busy LSU, an independent younger ALU-type
// instruction may be offered ahead of it. This is bounded to MAX_BYPASS
// consecutive overtakes of the same head.
//
// Optional feature macro: ISSUE_REORDER_BYPASS_EN
//   defined   -> out-of-order bypass of a stalled LOAD/STORE head is enabled
//   undefined -> strict in-order FIFO with empty pass-through; lsu_ready_i
//                and debug_req_i are ignored
//
// Ports
//   clk_i                clock, all state changes on the rising edge
//   rst_ni               asynchronous active-low reset
//   flush_i              pipeline flush, drops all buffered entries
//   debug_req_i          debug request, forces strict program order
//   issue_entry_i        decoded instruction from decode
//   issue_entry_valid_i  decode entry is valid
//   is_ctrl_flow_i       decode entry is a control-flow instruction
//   issue_instr_ack_o    decode entry is consumed this cycle
//   issue_entry_o        entry offered to issue
//   issue_entry_valid_o  offered entry is valid
//   is_ctrl_flow_o       offered entry is a control-flow instruction
//   issue_instr_ack_i    issue consumed the offered entry
//   lsu_ready_i          LSU can accept a request
// ----------------------------------------------------------------------------
package issue_reorder_pkg;

    typedef enum logic [2:0] {
        FU_NONE      = 3'd0,
        FU_LOAD      = 3'd1,
        FU_STORE     = 3'd2,
        FU_ALU       = 3'd3,
        FU_CTRL_FLOW = 3'd4,
        FU_MULT      = 3'd5,
        FU_CSR       = 3'd6
    } fu_t;

    typedef struct packed {
        logic [7:0] tag;
        fu_t        fu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } scoreboard_entry_t;

endpackage

module issue_reorder_window
    import issue_reorder_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_BYPASS = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              debug_req_i,
    input  scoreboard_entry_t issue_entry_i,
    input  logic              issue_entry_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              issue_instr_ack_o,
    output scoreboard_entry_t issue_entry_o,
    output logic              issue_entry_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_instr_ack_i,
    input  logic              lsu_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    scoreboard_entry_t entries_q  [DEPTH];
    scoreboard_entry_t entries_d  [DEPTH];
    logic              ctrlFlow_q [DEPTH];
    logic              ctrlFlow_d [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     postPopCount;

    logic [IW-1:0]     offerIdx;
    scoreboard_entry_t offeredEntry;
    logic              offeredCtrl;
    logic              bufEmpty;
    logic              popStored;
    logic              pushTail;

`ifdef ISSUE_REORDER_BYPASS_EN
    localparam int BW = $clog2(MAX_BYPASS + 1);
    localparam logic [BW-1:0] MAX_BYPASS_C = BW'(MAX_BYPASS);

    logic [BW-1:0] bypassCnt_q;
    logic [BW-1:0] bypassCnt_d;
    logic          headIsMem;
    logic          candFound;
    logic          clash;

    // A younger op may only overtake if it is neither a memory op nor a
    // control-flow op; those always stay in program order.
    function automatic logic isPlainOp(input fu_t fu);
        return (fu != FU_LOAD) && (fu != FU_STORE) && (fu != FU_CTRL_FLOW);
    endfunction

    // Any register overlap between a younger and an older entry blocks the
    // younger one: RAW, WAR and WAW, full index compare, x0 included.
    function automatic logic hazard(input scoreboard_entry_t young,
                                    input scoreboard_entry_t old);
        return (young.rs1 == old.rd)  || (young.rs2 == old.rd) ||
               (young.rd  == old.rs1) || (young.rd  == old.rs2) ||
               (young.rd  == old.rd);
    endfunction

    // Pick which slot to offer. Normally the head; if the head is a LOAD or
    // STORE that cannot go (LSU busy), not in debug mode and the overtake
    // budget is not used up, the oldest hazard-free plain op behind it wins.
    always_comb begin
        offerIdx  = '0;
        candFound = 1'b0;
        clash     = 1'b0;
        headIsMem = (entries_q[0].fu == FU_LOAD) || (entries_q[0].fu == FU_STORE);
        if (headIsMem && !lsu_ready_i && !debug_req_i && (bypassCnt_q < MAX_BYPASS_C)) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (!candFound && (k < int'(count_q)) && isPlainOp(entries_q[k].fu)) begin
                    clash = 1'b0;
                    for (int j = 0; j < k; j++) begin
                        if (hazard(entries_q[k], entries_q[j])) begin
                            clash = 1'b1;
                        end
                    end
                    if (!clash) begin
                        candFound = 1'b1;
                        offerIdx  = IW'(k);
                    end
                end
            end
        end
    end
`else
    // Without the bypass feature the head is always the offered slot, and the
    // LSU/debug inputs have no effect.
    logic unused_inputs;
    assign unused_inputs = lsu_ready_i ^ debug_req_i;

    always_comb begin
        offerIdx = '0;
    end
`endif

    // Output side: pass-through when empty, otherwise the selected slot.
    // A flush kills both handshakes for this cycle.
    always_comb begin
        bufEmpty     = (count_q == '0);
        offeredEntry = '0;
        offeredCtrl  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IW'(i) == offerIdx) begin
                offeredEntry = entries_q[i];
                offeredCtrl  = ctrlFlow_q[i];
            end
        end

        issue_instr_ack_o = (count_q < DEPTH_C) && !flush_i;

        if (bufEmpty) begin
            issue_entry_o       = issue_entry_i;
            is_ctrl_flow_o      = is_ctrl_flow_i;
            issue_entry_valid_o = issue_entry_valid_i && !flush_i;
        end else begin
            issue_entry_o       = offeredEntry;
            is_ctrl_flow_o      = offeredCtrl;
            issue_entry_valid_o = !flush_i;
        end

        // A stored entry leaves only when the buffer was non-empty; when empty,
        // an acknowledged input goes straight through and is never stored.
        popStored = !bufEmpty && !flush_i && issue_instr_ack_i;
        pushTail  = issue_entry_valid_i && issue_instr_ack_o &&
                    !(bufEmpty && issue_instr_ack_i);
    end

    // Next storage contents: close the gap left by the removed slot by
    // shifting everything behind it down one, then append the new entry at
    // the first free slot after that removal.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i]  = entries_q[i];
            ctrlFlow_d[i] = ctrlFlow_q[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (popStored && (IW'(i) >= offerIdx)) begin
                entries_d[i]  = entries_q[i+1];
                ctrlFlow_d[i] = ctrlFlow_q[i+1];
            end
        end
        if (popStored) begin
            entries_d[DEPTH-1]  = '0;
            ctrlFlow_d[DEPTH-1] = 1'b0;
        end

        postPopCount = count_q - CW'(popStored);
        for (int i = 0; i < DEPTH; i++) begin
            if (pushTail && (CW'(i) == postPopCount)) begin
                entries_d[i]  = issue_entry_i;
                ctrlFlow_d[i] = is_ctrl_flow_i;
            end
        end

        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = postPopCount + CW'(pushTail);
        end
    end

`ifdef ISSUE_REORDER_BYPASS_EN
    // Overtake budget: grows with every acknowledged overtake, restarts when
    // the head itself leaves, on flush, or whenever the buffer drains.
    always_comb begin
        bypassCnt_d = bypassCnt_q;
        if (flush_i || (count_d == '0)) begin
            bypassCnt_d = '0;
        end else if (popStored) begin
            if (offerIdx == '0) begin
                bypassCnt_d = '0;
            end else begin
                bypassCnt_d = bypassCnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypassCnt_q <= '0;
        end else begin
            bypassCnt_q <= bypassCnt_d;
        end
    end
`endif

    // State registers; reset discards everything that was buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i]  <= '0;
                ctrlFlow_q[i] <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i]  <= entries_d[i];
                ctrlFlow_q[i] <= ctrlFlow_d[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_reorder_window.sv
// ----------------------------------------------------------------------------
// tb_issue_reorder_window
//
// Self-checking bench for issue_reorder_window. A queue-based reference model
// tracks the buffered instructions in program order and decides what must be
// offered each cycle. Directed scenarios cover pass-through, full/flush and
// reset. Bypass scenarios are included when ISSUE_REORDER_BYPASS_EN is
// defined. A randomized phase then runs against the same model.
// ----------------------------------------------------------------------------
module tb_issue_reorder_window;
    import issue_reorder_pkg::*;

    localparam int DEPTH      = 4;
    localparam int MAX_BYPASS = 3;

    typedef struct {
        scoreboard_entry_t sbe;
        logic              ctrl;
    } modelEntry_t;

    logic              clk = 1'b0;
    logic              rstN;
    logic              flush;
    logic              debugReq;
    scoreboard_entry_t entryIn;
    logic              validIn;
    logic              ctrlIn;
    logic              ackOut;
    scoreboard_entry_t entryOut;
    logic              validOut;
    logic              ctrlOut;
    logic              ackIn;
    logic              lsuReady;

    modelEntry_t model[$];
    int          modelBypass = 0;
    int          lastPick    = 0;
    int          checkCount  = 0;
    int          failCount   = 0;
    int          tagSeq      = 8'h40;

    issue_reorder_window #(
        .DEPTH      (DEPTH),
        .MAX_BYPASS (MAX_BYPASS)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rstN),
        .flush_i             (flush),
        .debug_req_i         (debugReq),
        .issue_entry_i       (entryIn),
        .issue_entry_valid_i (validIn),
        .is_ctrl_flow_i      (ctrlIn),
        .issue_instr_ack_o   (ackOut),
        .issue_entry_o       (entryOut),
        .issue_entry_valid_o (validOut),
        .is_ctrl_flow_o      (ctrlOut),
        .issue_instr_ack_i   (ackIn),
        .lsu_ready_i         (lsuReady)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic scoreboard_entry_t mkEntry(input logic [7:0] tag, input fu_t fu,
                                                  input int rs1, input int rs2, input int rd);
        scoreboard_entry_t e;
        e.tag = tag;
        e.fu  = fu;
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.rd  = 5'(rd);
        return e;
    endfunction

    function automatic scoreboard_entry_t randEntry();
        fu_t fuTable[6] = '{FU_LOAD, FU_STORE, FU_ALU, FU_ALU, FU_CTRL_FLOW, FU_MULT};
        tagSeq = (tagSeq + 1) & 8'hff;
        return mkEntry(8'(tagSeq), fuTable[$urandom_range(0, 5)],
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    // Which buffered entry the rules say must be offered: the oldest, unless a
    // LOAD/STORE head is stuck and a later plain op shares no register with
    // anything ahead of it.
    function automatic int modelPick();
        int pick = 0;
`ifdef ISSUE_REORDER_BYPASS_EN
        if (model.size() > 1 && (model[0].sbe.fu == FU_LOAD || model[0].sbe.fu == FU_STORE) &&
            !lsuReady && !debugReq && modelBypass < MAX_BYPASS) begin
            for (int k = 1; k < model.size() && pick == 0; k++) begin
                fu_t f = model[k].sbe.fu;
                bit  blocked = (f == FU_LOAD || f == FU_STORE || f == FU_CTRL_FLOW);
                for (int j = 0; j < k; j++) begin
                    logic [4:0] yr[3];
                    logic [4:0] or_[3];
                    yr  = '{model[k].sbe.rs1, model[k].sbe.rs2, model[k].sbe.rd};
                    or_ = '{model[j].sbe.rs1, model[j].sbe.rs2, model[j].sbe.rd};
                    if (yr[0] == or_[2] || yr[1] == or_[2] ||
                        yr[2] == or_[0] || yr[2] == or_[1] || yr[2] == or_[2])
                        blocked = 1;
                end
                if (!blocked) pick = k;
            end
        end
`endif
        return pick;
    endfunction

    // Drive one cycle of inputs (at the falling edge) and check the
    // combinational outputs against the model shortly after.
    task automatic applyStimulus(input logic v, input scoreboard_entry_t e, input logic c,
                                 input logic ack, input logic fl, input logic lsu, input logic dbg);
        logic              expAck;
        logic              expValid;
        scoreboard_entry_t expE;
        logic              expC;
        validIn  = v;
        entryIn  = e;
        ctrlIn   = c;
        ackIn    = ack;
        flush    = fl;
        lsuReady = lsu;
        debugReq = dbg;
        #1;
        lastPick = modelPick();
        expAck   = (model.size() < DEPTH) && !fl;
        if (fl) begin
            expValid = 1'b0;
        end else if (model.size() == 0) begin
            expValid = v;
        end else begin
            expValid = 1'b1;
        end
        checkOutput("ack_o", 64'(ackOut), 64'(expAck));
        checkOutput("valid_o", 64'(validOut), 64'(expValid));
        if (expValid) begin
            if (model.size() == 0) begin
                expE = e;
                expC = c;
            end else begin
                expE = model[lastPick].sbe;
                expC = model[lastPick].ctrl;
            end
            checkOutput("entry_o", 64'(entryOut), 64'(expE));
            checkOutput("ctrl_o", 64'(ctrlOut), 64'(expC));
        end
    endtask

    // Advance through the rising edge, moving the model the same way.
    task automatic clockEdge();
        int          sizeBefore;
        modelEntry_t ne;
        @(posedge clk);
        sizeBefore = model.size();
        ne.sbe  = entryIn;
        ne.ctrl = ctrlIn;
        if (flush) begin
            model.delete();
            modelBypass = 0;
        end else if (sizeBefore == 0) begin
            if (validIn && !ackIn) model.push_back(ne);
        end else begin
            if (ackIn) begin
                model.delete(lastPick);
                if (lastPick == 0) modelBypass = 0;
                else               modelBypass++;
            end
            if (validIn && sizeBefore < DEPTH) model.push_back(ne);
            if (model.size() == 0) modelBypass = 0;
        end
        @(negedge clk);
    endtask

    task automatic pushOnly(input scoreboard_entry_t e);
        applyStimulus(1'b1, e, e.fu == FU_CTRL_FLOW, 1'b0, 1'b0, 1'b1, 1'b0);
        clockEdge();
    endtask

    task automatic flushCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clockEdge();
    endtask

    initial begin
        scoreboard_entry_t e;
        rstN     = 1'b0;
        validIn  = 1'b0;
        entryIn  = '0;
        ctrlIn   = 1'b0;
        ackIn    = 1'b0;
        flush    = 1'b0;
        lsuReady = 1'b1;
        debugReq = 1'b0;

        // Reset: empty pass-through, nothing valid with no input.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_valid_o", 64'(validOut), 64'(0));
        checkOutput("reset_ack_o", 64'(ackOut), 64'(1));
        rstN = 1'b1;
        @(negedge clk);

        // Empty + valid ADD + ack: same-cycle pass-through, nothing stored.
        e = mkEntry(8'h26, FU_ALU, 1, 2, 3);
        applyStimulus(1'b1, e, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("passthru_tag", 64'(entryOut.tag), 64'(8'h26));
        checkOutput("passthru_ack", 64'(ackOut), 64'(1));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("passthru_still_empty", 64'(validOut), 64'(0));
        clockEdge();

        // Fill to DEPTH, input refused; flush drops everything.
        for (int i = 0; i < DEPTH; i++) pushOnly(mkEntry(8'(8'h30 + i), FU_ALU, 1, 2, 3));
        applyStimulus(1'b1, mkEntry(8'h3f, FU_ALU, 1, 2, 3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("full_ack_o", 64'(ackOut), 64'(0));
        checkOutput("full_head_tag", 64'(entryOut.tag), 64'(8'h30));
        clockEdge();
        applyStimulus(1'b1, mkEntry(8'h3f, FU_ALU, 1, 2, 3), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_valid_o", 64'(validOut), 64'(0));
        checkOutput("flush_ack_o", 64'(ackOut), 64'(0));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_flush_ack_o", 64'(ackOut), 64'(1));
        checkOutput("post_flush_valid_o", 64'(validOut), 64'(0));
        clockEdge();

        // DEPTH-1 entries: push and pop in the same cycle both happen.
        for (int i = 0; i < DEPTH - 1; i++) pushOnly(mkEntry(8'(8'h50 + i), FU_ALU, 1, 2, 3));
        applyStimulus(1'b1, mkEntry(8'h5f, FU_ALU, 1, 2, 3), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("nearfull_ack_o", 64'(ackOut), 64'(1));
        checkOutput("nearfull_head_tag", 64'(entryOut.tag), 64'(8'h50));
        clockEdge();
        flushCycle();

`ifdef ISSUE_REORDER_BYPASS_EN
        // Stuck LOAD head, independent ADD behind it overtakes once.
        pushOnly(mkEntry(8'h27, FU_LOAD, 1, 1, 5));
        pushOnly(mkEntry(8'h28, FU_ALU, 3, 4, 6));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_add_tag", 64'(entryOut.tag), 64'(8'h28));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_load_stays", 64'(entryOut.tag), 64'(8'h27));
        clockEdge();
        flushCycle();

        // WAR on the STORE base register blocks the overtake.
        pushOnly(mkEntry(8'h60, FU_STORE, 2, 7, 9));
        pushOnly(mkEntry(8'h61, FU_ALU, 10, 11, 2));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("war_blocks", 64'(entryOut.tag), 64'(8'h60));
        clockEdge();
        flushCycle();

        // Debug forces program order.
        pushOnly(mkEntry(8'h27, FU_LOAD, 1, 1, 5));
        pushOnly(mkEntry(8'h28, FU_ALU, 3, 4, 6));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("debug_in_order", 64'(entryOut.tag), 64'(8'h27));
        clockEdge();
        flushCycle();

        // Overtake budget: three ALU ops pass, then the LOAD must go.
        pushOnly(mkEntry(8'h70, FU_LOAD, 1, 1, 5));
        pushOnly(mkEntry(8'h71, FU_ALU, 12, 13, 20));
        pushOnly(mkEntry(8'h72, FU_ALU, 14, 15, 21));
        pushOnly(mkEntry(8'h73, FU_ALU, 16, 17, 22));
        e = mkEntry(8'h74, FU_ALU, 18, 19, 23);
        applyStimulus(1'b1, e, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("budget_1", 64'(entryOut.tag), 64'(8'h71));
        clockEdge();
        applyStimulus(1'b1, e, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("budget_2", 64'(entryOut.tag), 64'(8'h72));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("budget_3", 64'(entryOut.tag), 64'(8'h73));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("budget_load", 64'(entryOut.tag), 64'(8'h70));
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("budget_after_load", 64'(entryOut.tag), 64'(8'h74));
        clockEdge();
        flushCycle();
`endif

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            e = randEntry();
            applyStimulus(($urandom % 4) != 0, e, e.fu == FU_CTRL_FLOW,
                          ($urandom % 5) < 3, ($urandom % 25) == 0,
                          ($urandom % 2) == 0, ($urandom % 10) == 0);
            clockEdge();
        end

        // Reset mid-operation discards buffered entries.
        pushOnly(mkEntry(8'h90, FU_LOAD, 1, 1, 5));
        pushOnly(mkEntry(8'h91, FU_ALU, 3, 4, 6));
        rstN = 1'b0;
        model.delete();
        modelBypass = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rstN = 1'b1;
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("reset_discard", 64'(validOut), 64'(0));
        clockEdge();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/issue_reorder_window.md
ISSUE_REORDER_WINDOW -- requirements
Module: issue_reorder_window

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered scoreboard entries; legal range 2..8.
REQ-002 SHALL have parameter MAX_BYPASS, default 3, meaning the maximum number of consecutive younger instructions allowed to overtake one held LOAD/STORE head; legal range 1..15.
REQ-003 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_i  in  1  pipeline flush.
REQ-006 SHALL have port debug_req_i  in  1  debug request; forces in-order operation.
REQ-007 SHALL have ports issue_entry_i  in  scoreboard_entry_t; issue_entry_valid_i  in  1; is_ctrl_flow_i  in  1: decoded instruction from the decode stage.
REQ-008 SHALL have port issue_instr_ack_o  out  1  the input entry is consumed this cycle.
REQ-009 SHALL have ports issue_entry_o  out  scoreboard_entry_t; issue_entry_valid_o  out  1; is_ctrl_flow_o  out  1: entry offered to issue.
REQ-010 SHALL have port issue_instr_ack_i  in  1  issue consumed the offered entry.
REQ-011 SHALL have port lsu_ready_i  in  1  LSU can accept a request.

Function
REQ-012 SHALL hold up to DEPTH entries {sbe, is_ctrl_flow} in program order (slot 0 = oldest) with occupancy count 0..DEPTH.
REQ-013 SHALL drive issue_instr_ack_o = (count < DEPTH) and not flush_i; a valid input with ack_o=1 is either issued directly (REQ-014) or pushed at the tail.
REQ-014 With count=0, SHALL pass input to output combinationally (zero latency); if issue_instr_ack_i=1 the entry is not stored, otherwise it is pushed into slot 0.
REQ-015 With count>0, SHALL offer the head unless a bypass candidate is selected (REQ-016); the input is then pushed at the tail if valid and count<DEPTH.
REQ-016 Bypass candidate: lowest-index slot k in 1..count-1 whose fu is not LOAD, STORE or CTRL_FLOW, and which has no RAW, WAR or WAW register conflict (full-index compare of rs1, rs2, rd, no x0 exemption) with any slot 0..k-1; selected only if head fu is LOAD or STORE, lsu_ready_i=0, bypass counter < MAX_BYPASS and debug_req_i=0.
REQ-017 On issue_instr_ack_i=1 with the offered slot k, SHALL remove slot k, shift slots k+1..count-1 down by one preserving order, and apply the tail push in the same cycle at the post-removal position.
REQ-018 SHALL increment the bypass counter on each acknowledged bypass, and clear it when the head is acknowledged or count becomes 0; counter width ceil(log2(MAX_BYPASS+1)), never exceeds MAX_BYPASS.
REQ-019 SHALL never offer a CTRL_FLOW, LOAD or STORE entry ahead of an older entry.
REQ-020 Simultaneous push and pop at count=DEPTH SHALL NOT occur (ack_o=0); at count=DEPTH-1 both SHALL complete, count unchanged.
REQ-021 On flush_i=1, SHALL force issue_entry_valid_o=0 and issue_instr_ack_o=0 that cycle and set count and bypass counter to 0 at the next edge; flush overrides any ack.

Reset
REQ-022 Asynchronous rst_ni=0 SHALL set count=0, bypass counter=0, all storage to zero; outputs then reflect count=0 pass-through, issue_entry_valid_o=0 when issue_entry_valid_i=0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered entries without issuing them.

Configuration
REQ-024 Macro ISSUE_REORDER_BYPASS_EN defined: bypass per REQ-016 active.
REQ-025 Macro ISSUE_REORDER_BYPASS_EN undefined: no candidate logic synthesized; block is a strict in-order DEPTH-entry FIFO with REQ-014 pass-through; ports unchanged, lsu_ready_i ignored.

Verification
REQ-026 Empty, valid ADD, ack_i=1 -> ADD on output same cycle, ack_o=1, count stays 0.
REQ-027 Head LOAD rd=x5, slot1 ADD rs1=x3 rd=x6, lsu_ready_i=0, ack_i=1 -> ADD offered and removed, LOAD stays head, bypass counter=1.
REQ-028 Head STORE rs1=x2, slot1 ADD rd=x2, lsu_ready_i=0 -> STORE offered (WAR blocks), no bypass.
REQ-029 MAX_BYPASS=3, LOAD head, lsu_ready_i=0, four independent ALU ops queued -> three bypass, fourth cycle offers LOAD; counter clears on LOAD ack.
REQ-030 DEPTH=4 full, valid input -> ack_o=0; flush_i=1 -> valid_o=0, next cycle count=0, ack_o=1.
REQ-031 debug_req_i=1 with REQ-027 setup -> LOAD offered, strict program order.
